dbus_amo_sequencer: RTL and testbench
=====================================

DBUS_AMO_SEQUENCER -- requirements
Module: dbus_amo_sequencer

Interface
REQ-001 SHALL have parameter NCORES, default `NCORES: number of requesting cores, 2..16.
REQ-002 SHALL have parameter DMEM_ADDRW, default `DMEM_ADDRW: word-address width of the data memory port.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_packed_i  input  NCORES  per-core AMO request; held high until the matching ack.
REQ-006 op_packed_i  input  4*NCORES  per-core AMO opcode, slice i = bits [4i+3:4i].
REQ-007 addr_packed_i  input  DMEM_ADDRW*NCORES  per-core word address.
REQ-008 wdata_packed_i  input  32*NCORES  per-core operand.
REQ-009 ack_packed_o  output  NCORES  one-cycle completion pulse, one-hot or zero.
REQ-010 rdata_o  output  32  old memory value, valid only in the ack cycle.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 mem_re_o, mem_we_o  output  1 each  memory read and write strobes.
REQ-013 mem_addr_o  output  DMEM_ADDRW  memory address.
REQ-014 mem_wdata_o  output  32  write data; mem_wstrb_o  output  4  byte strobes.
REQ-015 mem_rdata_i  input  32  read data, valid exactly one cycle after mem_re_o.

Function
REQ-016 SHALL implement FSM IDLE -> READ -> CALC -> WRITE -> IDLE, one cycle per state.
REQ-017 IDLE: if any req bit high, SHALL grant the first requester at or after rr_ptr (ascending, wrapping modulo NCORES), latch its index, op, addr and wdata, and go to READ; otherwise SHALL stay in IDLE.
REQ-018 On grant SHALL set rr_ptr to (granted index + 1) mod NCORES; with no grant rr_ptr SHALL hold.
REQ-019 READ: SHALL assert mem_re_o=1 with mem_addr_o = latched addr.
REQ-020 CALC: SHALL capture mem_rdata_i into old register and compute new = f(op, old, operand).
REQ-021 Opcodes: 0 SWAP(operand), 1 ADD (mod 2^32), 2 XOR, 3 AND, 4 OR, 5 MIN signed, 6 MAX signed, 7 MINU, 8 MAXU.
REQ-022 WRITE: for opcodes 0-8 SHALL assert mem_we_o=1, mem_wstrb_o=4'hF, mem_addr_o = latched addr, mem_wdata_o = new.
REQ-023 Opcodes 9-15 SHALL suppress the write (mem_we_o=0) and otherwise complete normally, returning the old value.
REQ-024 WRITE: SHALL assert ack bit of the granted core for exactly one cycle with rdata_o = old.
REQ-025 Request-to-ack latency SHALL be 4 cycles (grant at edge T0; ack during cycle T3); throughput 1 AMO per 4 cycles.
REQ-026 Requests arriving while not IDLE SHALL be ignored until the next IDLE cycle; inputs of non-granted cores SHALL NOT affect the active operation.
REQ-027 A req withdrawn after grant SHALL NOT abort the sequence.
REQ-028 When not in READ/WRITE, mem_re_o, mem_we_o, mem_wstrb_o, mem_addr_o and mem_wdata_o SHALL be 0; ack_packed_o and rdata_o SHALL be 0 outside WRITE.
REQ-029 Simultaneous requests from all cores SHALL each be served once in NCORES consecutive transactions.

Reset
REQ-030 While rst_ni=0: state=IDLE, rr_ptr=0, latched registers=0, all outputs 0, independent of clk_i.
REQ-031 Reset asserted mid-sequence SHALL abort immediately; no write strobe and no ack issued for that operation.
REQ-032 First grant after reset release SHALL occur on the first clk_i rising edge with rst_ni=1.

Verification
REQ-033 Core 0 ADD addr 0x10, mem=5, operand 3 -> mem_re at T1, mem_we at T3 with wdata 8, ack[0] at T3, rdata_o=5.
REQ-034 NCORES=4, all req high from reset, SWAP -> grants in order 0,1,2,3, acks 4 cycles apart, rr_ptr back to 0.
REQ-035 MIN signed, mem=0xFFFFFFFF, operand 1 -> write 0xFFFFFFFF; MINU same values -> write 0x00000001.
REQ-036 Opcode 12, mem=0xA5A5A5A5 -> no mem_we_o, ack pulse, rdata_o=0xA5A5A5A5.
REQ-037 rst_ni low during CALC -> mem_we_o and ack stay 0, state IDLE, rr_ptr 0; next request after release starts at core 0.
REQ-038 Core 2 req asserted while busy with core 1 -> core 2 granted in the first IDLE cycle after core 1's ack.

Source files
------------

// File: rtl/dbus_amo_sequencer.sv
// dbus_amo_sequencer: round-robin arbiter + read-modify-write AMO engine.
// Ports: clk_i/rst_ni; per-core req/op/addr/wdata in, ack out;
//   rdata_o old value in ack cycle; busy_o; single-port mem_* bus.
module dbus_amo_sequencer #(
  parameter int NCORES     = 4,
  parameter int DMEM_ADDRW = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            req_packed_i,
  input  logic [4*NCORES-1:0]          op_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  output logic [NCORES-1:0]            ack_packed_o,
  output logic [31:0]                  rdata_o,
  output logic                         busy_o,
  output logic                         mem_re_o,
  output logic                         mem_we_o,
  output logic [DMEM_ADDRW-1:0]        mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_wstrb_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {
    IDLE, READ, CALC, WRITE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]         rr_q, idx_q;
  logic [3:0]            op_q;
  logic [DMEM_ADDRW-1:0] addr_q;
  logic [31:0]           opnd_q, old_q, new_q;

  logic                  gnt_vld;
  logic [IW-1:0]         gnt_idx, cand;
  logic [3:0]            op_sel;
  logic [DMEM_ADDRW-1:0] addr_sel;
  logic [31:0]           wd_sel, new_c;

  // First requester at or after rr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = IW'((int'(rr_q) + i) % NCORES);
      if (!gnt_vld && req_packed_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    op_sel   = '0;
    addr_sel = '0;
    wd_sel   = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (gnt_idx == IW'(k)) begin
        op_sel   = op_packed_i[4*k +: 4];
        addr_sel = addr_packed_i[DMEM_ADDRW*k +: DMEM_ADDRW];
        wd_sel   = wdata_packed_i[32*k +: 32];
      end
    end
  end

  // mem_rdata_i is valid during CALC; result is registered for WRITE.
  always_comb begin
    unique case (op_q)
      4'd0:    new_c = opnd_q;
      4'd1:    new_c = mem_rdata_i + opnd_q;
      4'd2:    new_c = mem_rdata_i ^ opnd_q;
      4'd3:    new_c = mem_rdata_i & opnd_q;
      4'd4:    new_c = mem_rdata_i | opnd_q;
      4'd5:    new_c = ($signed(mem_rdata_i) < $signed(opnd_q))
                       ? mem_rdata_i : opnd_q;
      4'd6:    new_c = ($signed(mem_rdata_i) > $signed(opnd_q))
                       ? mem_rdata_i : opnd_q;
      4'd7:    new_c = (mem_rdata_i < opnd_q) ? mem_rdata_i : opnd_q;
      4'd8:    new_c = (mem_rdata_i > opnd_q) ? mem_rdata_i : opnd_q;
      default: new_c = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld) state_d = READ;
      READ:    state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      opnd_q  <= '0;
      old_q   <= '0;
      new_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_vld) begin
        idx_q  <= gnt_idx;
        op_q   <= op_sel;
        addr_q <= addr_sel;
        opnd_q <= wd_sel;
        rr_q   <= (gnt_idx == IW'(NCORES - 1))
                  ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == CALC) begin
        old_q <= mem_rdata_i;
        new_q <= new_c;
      end
    end
  end

  always_comb begin
    ack_packed_o = '0;
    rdata_o      = '0;
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wstrb_o  = '0;
    busy_o       = (state_q != IDLE);
    if (state_q == READ) begin
      mem_re_o   = 1'b1;
      mem_addr_o = addr_q;
    end
    if (state_q == WRITE) begin
      ack_packed_o[idx_q] = 1'b1;
      rdata_o    = old_q;
      mem_addr_o = addr_q;
      // Opcodes 9..15 complete as a plain read.
      if (op_q <= 4'd8) begin
        mem_we_o    = 1'b1;
        mem_wstrb_o = 4'hF;
        mem_wdata_o = new_q;
      end
    end
  end

endmodule

// File: tb/tb_dbus_amo_sequencer.sv
// tb_dbus_amo_sequencer: directed vector bench for dbus_amo_sequencer.
// Models a 1-cycle-latency word memory; checks bus, ack and rdata.
module tb_dbus_amo_sequencer;

  localparam int N  = 4;
  localparam int AW = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req = '0;
  logic [4*N-1:0]  op_p = '0;
  logic [AW*N-1:0] addr_p = '0;
  logic [32*N-1:0] wd_p = '0;
  logic [N-1:0]    ack;
  logic [31:0]     rdata_o;
  logic            busy_o;
  logic            mem_re_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [31:0]     mem_wdata_o;
  logic [3:0]      mem_wstrb_o;
  logic [31:0]     mem_rdata;
  logic [31:0]     mem [256];

  always #5 clk_i = ~clk_i;

  dbus_amo_sequencer #(.NCORES(N), .DMEM_ADDRW(AW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_packed_i   (req),
    .op_packed_i    (op_p),
    .addr_packed_i  (addr_p),
    .wdata_packed_i (wd_p),
    .ack_packed_o   (ack),
    .rdata_o        (rdata_o),
    .busy_o         (busy_o),
    .mem_re_o       (mem_re_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wstrb_o    (mem_wstrb_o),
    .mem_rdata_i    (mem_rdata)
  );

  always @(posedge clk_i) begin
    if (mem_re_o) mem_rdata <= mem[mem_addr_o];
    if (mem_we_o && mem_wstrb_o == 4'hF)
      mem[mem_addr_o] <= mem_wdata_o;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int c, input logic [3:0] op,
                       input logic [AW-1:0] a, input logic [31:0] w);
    op_p[4*c +: 4]    = op;
    addr_p[AW*c +: AW] = a;
    wd_p[32*c +: 32]  = w;
  endtask

  typedef struct {
    int          core;
    logic [3:0]  op;
    logic [AW-1:0] addr;
    logic [31:0] opnd;
    logic [31:0] init;
    logic [31:0] exp_wd;
    logic        exp_we;
  } vec_t;

  vec_t v[13];

  initial begin
    logic [N-1:0] exp_ack;
    logic [31:0]  exp_mem;

    v[0]  = '{0, 4'd1,  8'h10, 32'd3,        32'd5,        32'd8,        1'b1};
    v[1]  = '{1, 4'd0,  8'h20, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b1};
    v[2]  = '{2, 4'd2,  8'h21, 32'h0FF00FF0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b1};
    v[3]  = '{3, 4'd3,  8'h22, 32'hFF00FF00, 32'hF0F0F0F0, 32'hF000F000, 1'b1};
    v[4]  = '{0, 4'd4,  8'h23, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b1};
    v[5]  = '{1, 4'd5,  8'h24, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    v[6]  = '{2, 4'd7,  8'h25, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b1};
    v[7]  = '{3, 4'd6,  8'h26, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b1};
    v[8]  = '{0, 4'd8,  8'h27, 32'h80000000, 32'd7,        32'h80000000, 1'b1};
    v[9]  = '{1, 4'd12, 8'h28, 32'h11111111, 32'hA5A5A5A5, 32'h0,        1'b0};
    v[10] = '{2, 4'd1,  8'h29, 32'd2,        32'hFFFFFFFF, 32'h00000001, 1'b1};
    v[11] = '{3, 4'd9,  8'h2A, 32'd5,        32'd0,        32'h0,        1'b0};
    v[12] = '{0, 4'd5,  8'h2B, 32'h80000000, 32'd5,        32'h80000000, 1'b1};

    // All cores request SWAP straight out of reset.
    for (int c = 0; c < N; c++) begin
      drive(c, 4'd0, AW'(8'h40 + c), 32'hC0DE0000 + c);
      mem[8'h40 + c] = 32'h1000 + c;
    end
    req = '1;
    #22;
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst ack", {28'd0, ack}, 32'd0);
    chk("rst re/we", {30'd0, mem_re_o, mem_we_o}, 32'd0);
    chk("rst addr", {24'd0, mem_addr_o}, 32'd0);
    chk("rst rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_ack = (n % 4 == 3) ? N'(1) << ((n - 3) / 4) : '0;
      chk($sformatf("rr ack n%0d", n), {28'd0, ack}, {28'd0, exp_ack});
      if (n % 4 == 3)
        chk($sformatf("rr rdata n%0d", n), rdata_o,
            32'h1000 + (n - 3) / 4);
      req = req & ~ack;
    end
    for (int c = 0; c < N; c++)
      chk($sformatf("rr mem%0d", c), mem[8'h40 + c], 32'hC0DE0000 + c);

    // Pointer wrapped to 0: core 0 beats core 3.
    req = 4'b1001;
    tick();
    chk("wrap addr", {24'd0, mem_addr_o}, 32'h40);
    req = '0;
    tick(); tick(); tick();

    for (int i = 0; i < 13; i++) begin
      mem[v[i].addr] = v[i].init;
      for (int c = 0; c < N; c++)
        drive(c, 4'($urandom), AW'($urandom), $urandom);
      drive(v[i].core, v[i].op, v[i].addr, v[i].opnd);
      req = N'(1) << v[i].core;
      tick();
      chk($sformatf("v%0d re", i), {31'd0, mem_re_o}, 32'd1);
      chk($sformatf("v%0d raddr", i), {24'd0, mem_addr_o},
          {24'd0, v[i].addr});
      // Withdraw and scramble inputs; the op must still complete.
      req = '0;
      drive(v[i].core, 4'hF, ~v[i].addr, ~v[i].opnd);
      tick();
      chk($sformatf("v%0d calc", i), {28'd0, ack, mem_re_o, mem_we_o},
          32'd0);
      tick();
      chk($sformatf("v%0d ack", i), {28'd0, ack},
          32'(N'(1) << v[i].core));
      chk($sformatf("v%0d rdata", i), rdata_o, v[i].init);
      chk($sformatf("v%0d we", i), {31'd0, mem_we_o},
          {31'd0, v[i].exp_we});
      if (v[i].exp_we) begin
        chk($sformatf("v%0d wdata", i), mem_wdata_o, v[i].exp_wd);
        chk($sformatf("v%0d waddr", i), {24'd0, mem_addr_o},
            {24'd0, v[i].addr});
        chk($sformatf("v%0d wstrb", i), {28'd0, mem_wstrb_o}, 32'hF);
      end
      tick();
      exp_mem = v[i].exp_we ? v[i].exp_wd : v[i].init;
      chk($sformatf("v%0d idle", i), {27'd0, busy_o, ack}, 32'd0);
      chk($sformatf("v%0d mem", i), mem[v[i].addr], exp_mem);
    end

    // Core 2 arrives while core 1 is in flight.
    drive(1, 4'd1, 8'h50, 32'd1);
    drive(2, 4'd2, 8'h51, 32'h0F);
    mem[8'h50] = 32'd10;
    mem[8'h51] = 32'hF0;
    req = 4'b0010;
    tick();
    chk("busy c1 addr", {24'd0, mem_addr_o}, 32'h50);
    req = 4'b0110;
    tick(); tick();
    chk("busy c1 ack", {28'd0, ack}, 32'h2);
    chk("busy c1 rdata", rdata_o, 32'd10);
    req = 4'b0100;
    tick();
    chk("busy idle gap", {27'd0, busy_o, ack}, 32'd0);
    tick();
    chk("busy c2 addr", {23'd0, mem_re_o, mem_addr_o}, 32'h151);
    tick(); tick();
    chk("busy c2 ack", {28'd0, ack}, 32'h4);
    chk("busy c2 wdata", mem_wdata_o, 32'hFF);
    req = '0;
    tick();

    // Reset during CALC aborts the op and clears the pointer.
    drive(2, 4'd1, 8'h60, 32'd1);
    mem[8'h60] = 32'd100;
    req = 4'b0100;
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("abort async", {30'd0, busy_o, mem_re_o}, 32'd0);
    req = 4'b1001;
    drive(0, 4'd0, 8'h61, 32'h77);
    drive(3, 4'd0, 8'h62, 32'h88);
    tick();
    chk("abort we/ack", {27'd0, mem_we_o, ack}, 32'd0);
    chk("abort busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("abort regrant", {23'd0, mem_re_o, mem_addr_o}, 32'h161);
    tick(); tick();
    chk("abort ack0", {28'd0, ack}, 32'h1);
    req = '0;
    tick();
    chk("abort mem", mem[8'h60], 32'd100);
    chk("abort mem0", mem[8'h61], 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
